decode_stage: RTL and testbench

Decode stage of the five-stage SIMD-core pipeline, directly downstream of the fetch stage. It consumes the 26-bit `InstrD` and `PCPlus8D` from the fetch/decode register and decodes control signals. It reads and writes the 16×32 scalar register file and produces the decode/execute (D/E) pipeline register, with stall and flush driven by the hazard unit.

---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_decode_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: field decode, 16x32 register file read/write, and the D/E pipeline register.
// Decode and read are combinational; *E outputs follow InstrD by one clock; StallE holds, FlushE inserts a bubble.
module decode_stage #(
  parameter  int NREGS = 16,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [25:0]   InstrD,
  input  logic [DW-1:0] PCPlus8D,
  input  logic          RegWriteW,
  input  logic [AW-1:0] WA3W,
  input  logic [DW-1:0] ResultW,
  input  logic          StallE,
  input  logic          FlushE,
  output logic [AW-1:0] RA1D,
  output logic [AW-1:0] RA2D,
  output logic          RegWriteE,
  output logic          MemWriteE,
  output logic          MemtoRegE,
  output logic          BranchE,
  output logic          ALUSrcE,
  output logic          IllegalE,
  output logic [2:0]    ALUControlE,
  output logic [DW-1:0] RD1E,
  output logic [DW-1:0] RD2E,
  output logic [DW-1:0] ExtImmE,
  output logic [DW-1:0] PCPlus8E,
  output logic [AW-1:0] WA3E,
  output logic [AW-1:0] RA1E,
  output logic [AW-1:0] RA2E
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;

  localparam logic [AW-1:0] PC_REG = AW'(NREGS - 1);

  typedef struct packed {
    logic          reg_write;
    logic          mem_write;
    logic          memto_reg;
    logic          branch;
    logic          alu_src;
    logic          illegal;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] ext_imm;
    logic [DW-1:0] pc_plus8;
    logic [AW-1:0] wa3;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
  } de_t;

  logic [3:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rn;
  logic [AW-1:0] rm;
  logic [13:0]   imm14;
  logic [21:0]   imm22;

  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  logic [DW-1:0] rf [NREGS];

  de_t de_d;
  de_t de_q;

  assign op    = InstrD[25:22];
  assign rd    = InstrD[21:18];
  assign rn    = InstrD[17:14];
  assign rm    = InstrD[13:10];
  assign imm14 = InstrD[13:0];
  assign imm22 = InstrD[21:0];

  // Branches read the PC through port 1; stores read their data register through port 2.
  assign ra1  = (op == OP_B)   ? PC_REG : rn;
  assign ra2  = (op == OP_STR) ? rd     : rm;
  assign RA1D = ra1;
  assign RA2D = ra2;

  // PC read has priority over the writeback bypass, so r15 never sees ResultW.
  always_comb begin
    rd1 = rf[ra1];
    if (ra1 == PC_REG)
      rd1 = PCPlus8D;
    else if (RegWriteW && (WA3W == ra1))
      rd1 = ResultW;
  end

  always_comb begin
    rd2 = rf[ra2];
    if (ra2 == PC_REG)
      rd2 = PCPlus8D;
    else if (RegWriteW && (WA3W == ra2))
      rd2 = ResultW;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (RegWriteW && (WA3W != PC_REG)) begin
      rf[WA3W] <= ResultW;
    end
  end

  always_comb begin
    de_d           = '0;
    de_d.rd1       = rd1;
    de_d.rd2       = rd2;
    de_d.pc_plus8  = PCPlus8D;
    de_d.wa3       = rd;
    de_d.ra1       = ra1;
    de_d.ra2       = ra2;
    case (op)
      OP_NOP: ;
      OP_ADD: begin
        de_d.reg_write = 1'b1;
        de_d.alu_ctrl  = 3'b000;
      end
      OP_SUB: begin
        de_d.reg_write = 1'b1;
        de_d.alu_ctrl  = 3'b001;
      end
      OP_AND: begin
        de_d.reg_write = 1'b1;
        de_d.alu_ctrl  = 3'b010;
      end
      OP_OR: begin
        de_d.reg_write = 1'b1;
        de_d.alu_ctrl  = 3'b011;
      end
      OP_ADDI: begin
        de_d.reg_write = 1'b1;
        de_d.alu_src   = 1'b1;
        de_d.ext_imm   = {{(DW-14){1'b0}}, imm14};
      end
      OP_LDR: begin
        de_d.reg_write = 1'b1;
        de_d.memto_reg = 1'b1;
        de_d.alu_src   = 1'b1;
        de_d.ext_imm   = {{(DW-14){1'b0}}, imm14};
      end
      OP_STR: begin
        de_d.mem_write = 1'b1;
        de_d.alu_src   = 1'b1;
        de_d.ext_imm   = {{(DW-14){1'b0}}, imm14};
      end
      OP_B: begin
        de_d.branch    = 1'b1;
        de_d.alu_src   = 1'b1;
        de_d.ext_imm   = {{(DW-24){imm22[21]}}, imm22, 2'b00};
      end
      default: de_d.illegal = 1'b1;
    endcase
  end

  // Flush outranks stall so a squashed instruction cannot be held in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      de_q <= '0;
    else if (FlushE)
      de_q <= '0;
    else if (!StallE)
      de_q <= de_d;
  end

  assign RegWriteE   = de_q.reg_write;
  assign MemWriteE   = de_q.mem_write;
  assign MemtoRegE   = de_q.memto_reg;
  assign BranchE     = de_q.branch;
  assign ALUSrcE     = de_q.alu_src;
  assign IllegalE    = de_q.illegal;
  assign ALUControlE = de_q.alu_ctrl;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ExtImmE     = de_q.ext_imm;
  assign PCPlus8E    = de_q.pc_plus8;
  assign WA3E        = de_q.wa3;
  assign RA1E        = de_q.ra1;
  assign RA2E        = de_q.ra2;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expected D/E contents, a monitor checks them.
module tb_decode_stage;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        br;
    logic        src;
    logic        ill;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [31:0] pc;
    logic [3:0]  wa3;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
  } exp_t;

  localparam logic [31:0] R3 = 32'h1234_5678;
  localparam logic [31:0] R5 = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        RegWriteW;
  logic [3:0]  WA3W;
  logic [31:0] ResultW;
  logic        StallE;
  logic        FlushE;
  logic [3:0]  RA1D, RA2D;
  logic        RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, IllegalE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ExtImmE, PCPlus8E;
  logic [3:0]  WA3E, RA1E, RA2E;

  int    cyc    = 0;
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    due_q[$];
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  ldr_e;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
    .StallE(StallE), .FlushE(FlushE), .RA1D(RA1D), .RA2D(RA2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .PCPlus8E(PCPlus8E), .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t act();
    return {RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, IllegalE, ALUControlE,
            RD1E, RD2E, ExtImmE, PCPlus8E, WA3E, RA1E, RA2E};
  endfunction

  function automatic exp_t de(input logic rw, mw, m2r, br, src, ill, input logic [2:0] alu,
                              input logic [31:0] rd1, rd2, ext, pc,
                              input logic [3:0] wa3, ra1, ra2);
    return {rw, mw, m2r, br, src, ill, alu, rd1, rd2, ext, pc, wa3, ra1, ra2};
  endfunction

  function automatic logic [25:0] rt(input logic [3:0] op, rd, rn, rm);
    return {op, rd, rn, rm, 10'd0};
  endfunction

  function automatic logic [25:0] it(input logic [3:0] op, rd, rn, input logic [13:0] imm);
    return {op, rd, rn, imm};
  endfunction

  function automatic logic [25:0] bt(input logic [21:0] imm);
    return {4'b1000, imm};
  endfunction

  task automatic chk_de(input string nm, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chk_ra(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic push(input exp_t e, input string nm);
    due_q.push_back(cyc + 1);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic [25:0] ins, input logic [31:0] pc,
                       input logic rw, input logic [3:0] wa, input logic [31:0] res,
                       input logic st, input logic fl,
                       input logic [3:0] e1, input logic [3:0] e2,
                       input exp_t e, input string nm);
    InstrD = ins; PCPlus8D = pc; RegWriteW = rw; WA3W = wa; ResultW = res;
    StallE = st; FlushE = fl;
    push(e, nm);
    #1;
    chk_ra({nm, "_ra1d"}, RA1D, e1);
    chk_ra({nm, "_ra2d"}, RA2D, e2);
    @(negedge clk);
  endtask

  // Monitor: compares every scoreboard entry that falls due at this rising edge.
  always @(posedge clk) begin
    #1;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      if (due_q[0] != cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_late: got cycle %0d expected cycle %0d", name_q[0], cyc, due_q[0]);
      end else begin
        chk_de(name_q[0], act(), exp_q[0]);
      end
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; InstrD = '0; PCPlus8D = '0; RegWriteW = 1'b0; WA3W = '0;
    ResultW = '0; StallE = 1'b0; FlushE = 1'b0;
    #2 reset = 1'b0;
    #1 chk_de("reset_t0", act(), '0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      InstrD = 26'($urandom); PCPlus8D = $urandom; RegWriteW = 1'b1;
      WA3W = 4'($urandom); ResultW = $urandom;
      StallE = 1'($urandom); FlushE = 1'($urandom);
      push('0, "reset_hold");
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 1; i <= 14; i++)
      drive(rt(4'h1, 4'h0, 4'(i), 4'(i)), 32'h1000 + i, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'(i), 4'(i),
            de(1,0,0,0,0,0,3'b000, 32'h0, 32'h0, 32'h0, 32'h1000 + i, 4'h0, 4'(i), 4'(i)),
            $sformatf("read_zero_r%0d", i));

    drive(26'h0, 32'h20, 1, 4'd3, R3, 0, 0, 4'd0, 4'd0,
          de(0,0,0,0,0,0,3'b000, 0, 0, 0, 32'h20, 4'd0, 4'd0, 4'd0), "write_r3_nop");
    drive(rt(4'h1, 4'd4, 4'd3, 4'd3), 32'h24, 0, 4'd0, 0, 0, 0, 4'd3, 4'd3,
          de(1,0,0,0,0,0,3'b000, R3, R3, 0, 32'h24, 4'd4, 4'd3, 4'd3), "add_r3");
    drive(rt(4'h2, 4'd6, 4'd5, 4'd3), 32'h28, 1, 4'd5, R5, 0, 0, 4'd5, 4'd3,
          de(1,0,0,0,0,0,3'b001, R5, R3, 0, 32'h28, 4'd6, 4'd5, 4'd3), "bypass_sub");
    drive(rt(4'h3, 4'd7, 4'd5, 4'd4), 32'h2C, 0, 4'd0, 0, 0, 0, 4'd5, 4'd4,
          de(1,0,0,0,0,0,3'b010, R5, 0, 0, 32'h2C, 4'd7, 4'd5, 4'd4), "and_stored");
    drive(rt(4'h4, 4'd1, 4'd3, 4'd5), 32'h30, 0, 4'd0, 0, 0, 0, 4'd3, 4'd5,
          de(1,0,0,0,0,0,3'b011, R3, R5, 0, 32'h30, 4'd1, 4'd3, 4'd5), "or");
    drive(it(4'h5, 4'd2, 4'd3, 14'h3FFF), 32'h34, 0, 4'd0, 0, 0, 0, 4'd3, 4'd15,
          de(1,0,0,0,1,0,3'b000, R3, 32'h34, 32'h3FFF, 32'h34, 4'd2, 4'd3, 4'd15), "addi");
    drive(bt(22'h3FFFFE), 32'h100, 0, 4'd0, 0, 0, 0, 4'd15, 4'd15,
          de(0,0,0,1,1,0,3'b000, 32'h100, 32'h100, 32'hFFFF_FFF8, 32'h100, 4'd15, 4'd15, 4'd15),
          "branch_neg");
    drive(bt(22'h000004), 32'h200, 0, 4'd0, 0, 0, 0, 4'd15, 4'd0,
          de(0,0,0,1,1,0,3'b000, 32'h200, 0, 32'h10, 32'h200, 4'd0, 4'd15, 4'd0), "branch_pos");
    drive(rt(4'h1, 4'd0, 4'd15, 4'd15), 32'h300, 1, 4'd15, 32'hDEAD, 0, 0, 4'd15, 4'd15,
          de(1,0,0,0,0,0,3'b000, 32'h300, 32'h300, 0, 32'h300, 4'd0, 4'd15, 4'd15), "r15_write");
    drive(rt(4'h1, 4'd0, 4'd15, 4'd15), 32'h304, 0, 4'd0, 0, 0, 0, 4'd15, 4'd15,
          de(1,0,0,0,0,0,3'b000, 32'h304, 32'h304, 0, 32'h304, 4'd0, 4'd15, 4'd15), "r15_after");
    drive(it(4'h7, 4'd3, 4'd5, 14'h0010), 32'h40, 0, 4'd0, 0, 0, 0, 4'd5, 4'd3,
          de(0,1,0,0,1,0,3'b000, R5, R3, 32'h10, 32'h40, 4'd3, 4'd5, 4'd3), "str");
    ldr_e = de(1,0,1,0,1,0,3'b000, R3, 0, 32'h4, 32'h44, 4'd8, 4'd3, 4'd0);
    drive(it(4'h6, 4'd8, 4'd3, 14'h0004), 32'h44, 0, 4'd0, 0, 0, 0, 4'd3, 4'd0, ldr_e, "ldr");
    drive(rt(4'h1, 4'd9, 4'd5, 4'd3), 32'h48, 1, 4'd9, 32'h99, 1, 0, 4'd5, 4'd3, ldr_e, "stall1");
    drive(rt(4'h1, 4'd9, 4'd5, 4'd3), 32'h48, 0, 4'd0, 0, 1, 0, 4'd5, 4'd3, ldr_e, "stall2");
    drive(rt(4'h1, 4'd9, 4'd5, 4'd3), 32'h4C, 0, 4'd0, 0, 1, 1, 4'd5, 4'd3, '0, "flush_stall");
    drive(rt(4'h1, 4'd9, 4'd9, 4'd5), 32'h50, 0, 4'd0, 0, 0, 0, 4'd9, 4'd5,
          de(1,0,0,0,0,0,3'b000, 32'h99, R5, 0, 32'h50, 4'd9, 4'd9, 4'd5), "after_flush");
    drive(it(4'h6, 4'd8, 4'd3, 14'h0004), 32'h54, 0, 4'd0, 0, 0, 1, 4'd3, 4'd0, '0, "flush");
    drive(rt(4'hA, 4'd2, 4'd3, 4'd4), 32'h60, 0, 4'd0, 0, 0, 0, 4'd3, 4'd4,
          de(0,0,0,0,0,1,3'b000, R3, 0, 0, 32'h60, 4'd2, 4'd3, 4'd4), "illegal_a");
    drive(rt(4'hF, 4'd1, 4'd5, 4'd3), 32'h64, 0, 4'd0, 0, 0, 0, 4'd5, 4'd3,
          de(0,0,0,0,0,1,3'b000, R5, R3, 0, 32'h64, 4'd1, 4'd5, 4'd3), "illegal_f");
    drive(rt(4'h1, 4'd4, 4'd3, 4'd5), 32'h68, 0, 4'd0, 0, 0, 0, 4'd3, 4'd5,
          de(1,0,0,0,0,0,3'b000, R3, R5, 0, 32'h68, 4'd4, 4'd3, 4'd5), "pre_reset");

    reset = 1'b0;
    #1 chk_de("reset_async", act(), '0);
    @(negedge clk);
    reset = 1'b1;
    drive(rt(4'h1, 4'd0, 4'd3, 4'd5), 32'h70, 0, 4'd0, 0, 0, 0, 4'd3, 4'd5,
          de(1,0,0,0,0,0,3'b000, 0, 0, 0, 32'h70, 4'd0, 4'd3, 4'd5), "post_reset_read");

    repeat (3) @(negedge clk);
    while (due_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_unchecked: got no check expected cycle %0d", name_q[0], due_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
